// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD subtractor.
// Holds the FSM state encoding, BCD digit constants and a digit-valid check.
// No ports; imported by bcd_digit_sub and bcd_serial_subtractor.
package bcd_pkg;

    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SUB    = 2'd1,
        S_RECOMP = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // True when a 4-bit nibble is a legal BCD digit (0..9).
    function automatic logic is_bcd(input logic [3:0] dig);
        return (dig <= 4'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = a - b - bin, folded back into 0..9 with borrow out.
// Latency: combinational. Backpressure: none.
// Ports: a_i/b_i digits in 0..9, bin_i borrow in; d_o result digit, bout_o borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bin_i,
    output logic [3:0] d_o,
    output logic       bout_o
);

    // Range of a - b - bin is -10..9, which fits a 5-bit signed value.
    logic signed [4:0] raw;
    logic signed [4:0] adj;

    always_comb begin
        raw = $signed({1'b0, a_i}) - $signed({1'b0, b_i}) - $signed({4'b0000, bin_i});
        adj = raw + $signed(5'(BCD_RADIX));
        if (raw < 0) begin
            d_o    = adj[3:0];
            bout_o = 1'b1;
        end else begin
            d_o    = raw[3:0];
            bout_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: sign-magnitude |A-B|, one digit per clock, LSD first.
// Latency: DIGITS+1 cycles (A>=B), 2*DIGITS+1 (A<B, ten's complement pass), 1 (invalid digit).
// Backpressure: inp_start is only honoured in IDLE or DONE; starts while busy are dropped.
// Ports: inp_clk/inp_rst (async, active-high); inp_start, inp_A, inp_B request;
//        out_busy, out_done (1-cycle pulse), out_diff, out_neg, out_invalid results.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                inp_clk,
    input  logic                inp_rst,
    input  logic                inp_start,
    input  logic [4*DIGITS-1:0] inp_A,
    input  logic [4*DIGITS-1:0] inp_B,
    output logic                out_busy,
    output logic                out_done,
    output logic [4*DIGITS-1:0] out_diff,
    output logic                out_neg,
    output logic                out_invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             neg_q, neg_d;
    logic             inv_q, inv_d;

    // Shared digit subtractor operands (SUB: A[i]-B[i]; RECOMP: 0-work[i]).
    logic [3:0] sub_a, sub_b, sub_d;
    logic       sub_bin, sub_bout;

    logic [3:0] a_dig, b_dig, w_dig;
    logic       any_bad;

    bcd_digit_sub u_digit (
        .a_i    (sub_a),
        .b_i    (sub_b),
        .bin_i  (sub_bin),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    // Current digit selection; the index never exceeds DIGITS-1.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        w_dig = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == k[IDX_W-1:0]) begin
                a_dig = a_q[k*4 +: 4];
                b_dig = b_q[k*4 +: 4];
                w_dig = work_q[k*4 +: 4];
            end
        end
    end

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(inp_A[k*4 +: 4]) || !is_bcd(inp_B[k*4 +: 4])) begin
                any_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        inv_d    = inv_q;
        sub_a    = 4'd0;
        sub_b    = 4'd0;
        sub_bin  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (inp_start) begin
                    a_d      = inp_A;
                    b_d      = inp_B;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    work_d   = '0;
                    if (any_bad) begin
                        state_d = S_DONE;
                        diff_d  = '0;
                        neg_d   = 1'b0;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_SUB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SUB: begin
                sub_a    = a_dig;
                sub_b    = b_dig;
                sub_bin  = borrow_q;
                borrow_d = sub_bout;
                idx_d    = idx_q + IDX_W'(1);
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == k[IDX_W-1:0]) work_d[k*4 +: 4] = sub_d;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (sub_bout) begin
                        // Wrapped below zero: work holds 10^DIGITS + (A-B).
                        state_d  = S_RECOMP;
                        borrow_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        diff_d  = work_d;
                        neg_d   = 1'b0;
                        inv_d   = 1'b0;
                    end
                end
            end

            S_RECOMP: begin
                sub_a    = 4'd0;
                sub_b    = w_dig;
                sub_bin  = borrow_q;
                borrow_d = sub_bout;
                idx_d    = idx_q + IDX_W'(1);
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == k[IDX_W-1:0]) work_d[k*4 +: 4] = sub_d;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = S_DONE;
                    diff_d   = work_d;
                    neg_d    = 1'b1;
                    inv_d    = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            inv_q    <= inv_d;
        end
    end

    assign out_busy    = (state_q == S_SUB) || (state_q == S_RECOMP);
    assign out_done    = (state_q == S_DONE);
    assign out_diff    = diff_q;
    assign out_neg     = neg_q;
    assign out_invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

    logic        inp_clk = 1'b0;
    logic        inp_rst;
    logic        inp_start;
    logic [15:0] inp_A;
    logic [15:0] inp_B;
    logic        out_busy;
    logic        out_done;
    logic [15:0] out_diff;
    logic        out_neg;
    logic        out_invalid;

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .inp_clk     (inp_clk),
        .inp_rst     (inp_rst),
        .inp_start   (inp_start),
        .inp_A       (inp_A),
        .inp_B       (inp_B),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_diff    (out_diff),
        .out_neg     (out_neg),
        .out_invalid (out_invalid)
    );

    always #5 inp_clk = ~inp_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle (cycle t), then scrambles the operands so any
    // late sampling shows up. Returns #1 after the sampling edge (cycle t+1).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        inp_A     = a;
        inp_B     = b;
        inp_start = 1'b1;
        @(posedge inp_clk);
        #1;
        inp_start = 1'b0;
        inp_A     = 16'h7777;
        inp_B     = 16'h3333;
    endtask

    // Waits for out_done starting at cycle index cyc0; reports the cycle index
    // of done and how many busy cycles were seen. Bounded.
    task automatic wait_done(input int cyc0, output int lat, output int busy_cnt);
        lat      = cyc0;
        busy_cnt = 0;
        while (!out_done && lat < 40) begin
            if (out_busy) busy_cnt++;
            @(posedge inp_clk);
            #1;
            lat++;
        end
        if (!out_done) lat = -1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input int exp_busy, input logic [15:0] exp_diff,
                          input logic exp_neg, input logic exp_inv);
        int lat, bc;
        start_op(a, b);
        wait_done(1, lat, bc);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bc, exp_busy);
        check({tag, "_diff"}, out_diff, exp_diff);
        check({tag, "_neg"}, out_neg, exp_neg);
        check({tag, "_inv"}, out_invalid, exp_inv);
        @(posedge inp_clk);
        #1;
        check({tag, "_pulse"}, out_done, 1'b0);
    endtask

    initial begin
        int lat, bc;
        inp_rst   = 1'b1;
        inp_start = 1'b0;
        inp_A     = '0;
        inp_B     = '0;
        #12;
        check("rst_busy", out_busy, 1'b0);
        check("rst_done", out_done, 1'b0);
        check("rst_diff", out_diff, 16'h0000);
        check("rst_neg",  out_neg, 1'b0);
        check("rst_inv",  out_invalid, 1'b0);
        @(negedge inp_clk);
        inp_rst = 1'b0;
        @(posedge inp_clk);
        #1;

        // 1: positive difference with borrows
        run_op("t1", 16'h5032, 16'h1747, 5, 4, 16'h3285, 1'b0, 1'b0);
        // 2: negative difference, recomplement pass
        run_op("t2", 16'h0100, 16'h0250, 9, 8, 16'h0150, 1'b1, 1'b0);
        // 3: equal operands, then smallest negative
        run_op("t3a", 16'h9999, 16'h9999, 5, 4, 16'h0000, 1'b0, 1'b0);
        run_op("t3b", 16'h0000, 16'h0001, 9, 8, 16'h0001, 1'b1, 1'b0);
        // 4: invalid digit
        run_op("t4", 16'h12A4, 16'h0001, 1, 0, 16'h0000, 1'b0, 1'b1);

        // 5: start while busy is ignored; start during DONE is accepted
        start_op(16'h0500, 16'h0100);              // now cycle t+1
        @(posedge inp_clk);
        #1;                                        // cycle t+2
        inp_A     = 16'h0001;
        inp_B     = 16'h0002;
        inp_start = 1'b1;
        @(posedge inp_clk);
        #1;                                        // cycle t+3
        inp_start = 1'b0;
        check("t5_hold_mid", out_diff, 16'h0000);
        wait_done(3, lat, bc);
        check("t5a_lat",  lat, 5);
        check("t5a_diff", out_diff, 16'h0400);
        check("t5a_neg",  out_neg, 1'b0);
        start_op(16'h0020, 16'h0007);              // pulsed in the DONE cycle
        check("t5b_busy", out_busy, 1'b1);
        check("t5b_hold", out_diff, 16'h0400);
        wait_done(1, lat, bc);
        check("t5b_lat",  lat, 5);
        check("t5b_diff", out_diff, 16'h0013);
        check("t5b_neg",  out_neg, 1'b0);
        @(posedge inp_clk);
        #1;

        // 6: reset mid-operation from a non-zero prior result
        start_op(16'h0100, 16'h0250);              // cycle t+1
        @(posedge inp_clk);
        #1;                                        // cycle t+2
        @(posedge inp_clk);
        #1;                                        // cycle t+3
        inp_rst = 1'b1;
        #1;
        check("t6_rst_busy", out_busy, 1'b0);
        check("t6_rst_done", out_done, 1'b0);
        check("t6_rst_diff", out_diff, 16'h0000);
        check("t6_rst_neg",  out_neg, 1'b0);
        @(negedge inp_clk);
        inp_rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge inp_clk);
            #1;
            if (out_done || out_busy) bc++;
        end
        check("t6_no_done", bc, 0);
        run_op("t6b", 16'h9999, 16'h0000, 5, 4, 16'h9999, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Digit-serial, multi-digit BCD subtractor: computes A − B on packed BCD operands, one digit per clock, LSD first.
- Produces a sign-magnitude BCD result. On a negative difference, a second serial pass takes the ten's complement of the intermediate result.
- Counterpart to the team's combinational BCD adder. Sits in the same arithmetic datapath and is driven by a start/done handshake from the controlling FSM.

Parameters:
- DIGITS, 4, number of BCD digits per operand (operand width = 4*DIGITS).

Ports:
- inp_clk  input  1  system clock, rising edge.
- inp_rst  input  1  asynchronous, active-high reset.
- inp_start  input  1  request; accepted only when the FSM is in IDLE or DONE.
- inp_A  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
- inp_B  input  4*DIGITS  subtrahend, packed BCD.
- out_busy  output  1  high while in SUB or RECOMP.
- out_done  output  1  one-cycle completion pulse.
- out_diff  output  4*DIGITS  magnitude |A−B|, packed BCD.
- out_neg  output  1  1 when A < B.
- out_invalid  output  1  1 when any digit of inp_A or inp_B is greater than 9.

Behaviour:
- One clock, inp_clk. Reset is asynchronous and active-high on inp_rst.
- Reset values: state=IDLE; out_busy, out_done, out_neg, out_invalid = 0; out_diff = 0. All internal registers also clear to 0.
- States and transitions:
  - IDLE: on inp_start, latch inp_A and inp_B, clear borrow, set digit index i=0.
    - Any input digit > 9 → DONE with invalid=1, diff=0, neg=0.
    - Otherwise → SUB.
  - SUB: each cycle compute d = A[i] − B[i] − borrow. If d < 0, write d+10 and set borrow=1; else write d and set borrow=0. Store into work register digit i, then i++.
    - After digit DIGITS−1: final borrow=0 → DONE, neg=0.
    - After digit DIGITS−1: final borrow=1 → RECOMP, with i=0 and borrow cleared.
  - RECOMP: each cycle work[i] = 0 − work[i] − borrow, using the same digit rule. This yields 10^DIGITS − work, which equals B − A.
    - After the last digit → DONE, neg=1.
  - DONE: out_done=1 for exactly this cycle.
    - inp_start high → accepted as in IDLE.
    - Otherwise → IDLE.
- Output update: out_diff, out_neg and out_invalid load from the work registers on the edge that enters DONE. They hold until the next operation enters DONE. They do not change mid-operation.
- Latency, with start sampled at edge t:
  - out_done rises at edge t+DIGITS+1 for A ≥ B.
  - out_done rises at edge t+2*DIGITS+1 for A < B.
  - out_done rises at edge t+1 for invalid input.
- Boundary rules:
  - inp_start while busy is ignored; the operands are not re-latched.
  - A == B gives diff=0 and neg=0. Zero is never reported negative.
  - Input changes after acceptance have no effect.
  - Reset mid-SUB or mid-RECOMP aborts the operation. Outputs return to reset values and no done pulse is produced.
  - Digit index wraps only via the explicit state exit; no index beyond DIGITS−1 is ever used.
- Width rules:
  - Per-digit arithmetic uses a 5-bit signed intermediate.
  - Each result digit is always in 0..9.

Decomposition:
- Shared package bcd_pkg holds:
  - State encoding constants S_IDLE, S_SUB, S_RECOMP, S_DONE (2 bits).
  - BCD_MAX = 9 and BCD_RADIX = 10.
  - Digit-valid check function is_bcd(4-bit).
- Sub-module bcd_digit_sub, combinational: inputs a[3:0], b[3:0], bin; outputs d[3:0], bout.
  - One instance, shared by SUB (a=A[i], b=B[i]) and RECOMP (a=0, b=work[i]), selected by a mux.
- Top module holds the FSM, index counter, borrow flop, operand and work registers, and output registers.

Test Plan (DIGITS=4):
1. A=0x5032, B=0x1747, start pulse at t → out_done at t+5; diff=0x3285, neg=0, invalid=0; busy high t+1..t+4.
2. A=0x0100, B=0x0250 → out_done at t+9; diff=0x0150, neg=1.
3. A=0x9999, B=0x9999, then A=0x0000, B=0x0001 → first result diff=0x0000 neg=0; second result diff=0x0001 neg=1.
4. A=0x12A4, B=0x0001 → out_done at t+1; invalid=1, diff=0x0000, neg=0.
5. Start A=0x0500, B=0x0100; re-pulse start with A=0x0001, B=0x0002 at t+2 → second pulse ignored; diff=0x0400, neg=0 at t+5. Then pulse start during the DONE cycle with A=0x0020, B=0x0007 → accepted; diff=0x0013 at done+5.
6. Assert inp_rst at t+3 of A=0x0100, B=0x0250 (from a prior-result state) → all outputs 0 immediately, no out_done. After release, A=0x9999, B=0x0000 gives diff=0x9999, neg=0.
